// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction fetch controller, PC owner and IR writer over a req/ack memory port
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   fetch_en, pc_ld, pc_in start a fetch / load PC from pc_in (both sampled only in IDLE)
//   err_clr                clears the sticky bus_err flag
//   mem_req, mem_addr      memory read request and address (address held for the whole request)
//   mem_rdata, mem_ack     memory read data and completion
//   ir_data, ld_ir         instruction word plus its one-cycle IR load strobe
//   fetch_done, busy       one-cycle completion pulse; high from request until back in IDLE
//   bus_err, pc_out        sticky memory-timeout flag; current PC
module ifetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        pc_ld,
    input  logic [15:0] pc_in,
    input  logic        err_clr,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] ir_data,
    output logic        ld_ir,
    output logic        fetch_done,
    output logic        busy,
    output logic        bus_err,
    output logic [15:0] pc_out
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [15:0] pc_n, mem_addr_n, ir_data_n;
    logic        mem_req_n, ld_ir_n, fetch_done_n, busy_n, bus_err_n;
    logic        start, ack, tmo;
    assign start = state == IDLE && fetch_en;
    assign ack   = state == WAIT && mem_ack;
    // ack on the last allowed cycle takes priority over the timeout
    assign tmo   = state == WAIT && !mem_ack && cnt == 8'(TIMEOUT - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            pc_out     <= RESET_PC;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            ir_data    <= '0;
            ld_ir      <= 1'b0;
            fetch_done <= 1'b0;
            busy       <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            pc_out     <= pc_n;
            mem_req    <= mem_req_n;
            mem_addr   <= mem_addr_n;
            ir_data    <= ir_data_n;
            ld_ir      <= ld_ir_n;
            fetch_done <= fetch_done_n;
            busy       <= busy_n;
            bus_err    <= bus_err_n;
        end
    end
    always_comb begin
        state_n = state == DONE ? IDLE : (ack || tmo) ? DONE : start ? WAIT : state;
    end
    always_comb begin
        pc_n         = ack ? pc_out + 16'd1 : (state == IDLE && pc_ld) ? pc_in : pc_out;
        // a same-cycle pc_ld redirects the fetch to the new target
        mem_addr_n   = start ? (pc_ld ? pc_in : pc_out) : mem_addr;
        mem_req_n    = start ? 1'b1 : (ack || tmo) ? 1'b0 : mem_req;
        cnt_n        = start ? 8'd0 : state == WAIT ? cnt + 8'd1 : cnt;
        ir_data_n    = ack ? mem_rdata : ir_data;
        ld_ir_n      = ack;
        fetch_done_n = ack || tmo;
        busy_n       = start ? 1'b1 : state == DONE ? 1'b0 : busy;
        bus_err_n    = tmo ? 1'b1 : err_clr ? 1'b0 : bus_err;
    end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed vectors against a transaction-level model of the fetch controller
module tb_ifetch_ctrl;
    localparam int TIMEOUT = 15;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0, pc_ld = 1'b0, err_clr = 1'b0, mem_ack = 1'b0;
    logic [15:0] pc_in = '0, mem_rdata = '0;
    logic        mem_req, ld_ir, fetch_done, busy, bus_err;
    logic [15:0] mem_addr, ir_data, pc_out;
    int vectors = 0, miscompares = 0, req_cycles = 0;

    ifetch_ctrl #(.RESET_PC(16'h0000), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc_ld(pc_ld), .pc_in(pc_in),
        .err_clr(err_clr), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .ir_data(ir_data), .ld_ir(ld_ir), .fetch_done(fetch_done),
        .busy(busy), .bus_err(bus_err), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: a fetch is "outstanding" from request until ack or TIMEOUT unanswered cycles,
    // then one completion cycle, then idle again.
    bit          m_req = 0, m_busy = 0, m_ld = 0, m_done = 0, m_err = 0, m_fin = 0;
    int          m_wait = 0;
    logic [15:0] m_pc = '0, m_addr = '0, m_ir = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_req = 0; m_busy = 0; m_ld = 0; m_done = 0; m_err = 0; m_fin = 0;
            m_wait = 0; m_pc = '0; m_addr = '0; m_ir = '0;
        end else begin
            m_ld = 0;
            m_done = 0;
            if (err_clr) m_err = 0;
            if (m_fin) begin
                m_fin = 0;
                m_busy = 0;
            end else if (m_req) begin
                if (mem_ack) begin
                    m_ir = mem_rdata; m_pc = m_pc + 16'd1;
                    m_ld = 1; m_done = 1; m_req = 0; m_fin = 1;
                end else begin
                    m_wait++;
                    if (m_wait == TIMEOUT) begin
                        m_err = 1; m_done = 1; m_req = 0; m_fin = 1;
                    end
                end
            end else begin
                if (pc_ld) m_pc = pc_in;
                if (fetch_en) begin
                    m_addr = m_pc; m_req = 1; m_busy = 1; m_wait = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req) req_cycles++;
            chk("mem_req", mem_req, m_req);
            chk("mem_addr", mem_addr, m_addr);
            chk("ir_data", ir_data, m_ir);
            chk("ld_ir", ld_ir, m_ld);
            chk("fetch_done", fetch_done, m_done);
            chk("busy", busy, m_busy);
            chk("bus_err", bus_err, m_err);
            chk("pc_out", pc_out, m_pc);
        end
    end

    // Ends on the negedge of the completion (DONE) cycle.
    task automatic do_fetch(input bit ld, input logic [15:0] tgt, input int waits, input logic [15:0] data);
        @(negedge clk); pc_ld = ld; pc_in = tgt; fetch_en = 1;
        @(negedge clk); pc_ld = 0; fetch_en = 0;
        repeat (waits) @(negedge clk);
        mem_ack = 1; mem_rdata = data;
        @(negedge clk); mem_ack = 0;
    endtask

    task automatic to_fetch(input bit clr);
        @(negedge clk); fetch_en = 1; err_clr = clr; req_cycles = 0;
        @(negedge clk); fetch_en = 0;
        repeat (TIMEOUT) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_req", mem_req, 1'b0);
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        // 1: zero-wait fetch from address 0
        @(negedge clk); fetch_en = 1;
        @(negedge clk); fetch_en = 0; mem_ack = 1; mem_rdata = 16'hA5C3;
        chk("t1_req", mem_req, 1'b1);
        chk("t1_addr", mem_addr, 16'h0000);
        @(negedge clk); mem_ack = 0;
        chk("t1_ld", ld_ir, 1'b1);
        chk("t1_ir", ir_data, 16'hA5C3);
        chk("t1_done", fetch_done, 1'b1);
        chk("t1_pc", pc_out, 16'h0001);
        chk("t1_model_pc", m_pc, 16'h0001);
        @(negedge clk);
        chk("t1_busy", busy, 1'b0);
        chk("t1_ld_off", ld_ir, 1'b0);
        // 2: load-and-fetch, ack after 3 wait cycles, address stable throughout
        @(negedge clk); pc_ld = 1; pc_in = 16'h1234; fetch_en = 1;
        @(negedge clk); pc_ld = 0; fetch_en = 0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_addr", mem_addr, 16'h1234);
            chk("t2_req", mem_req, 1'b1);
            if (i == 3) begin mem_ack = 1; mem_rdata = 16'h0F0F; end
            @(negedge clk);
        end
        mem_ack = 0;
        chk("t2_pc", pc_out, 16'h1235);
        chk("t2_model_pc", m_pc, 16'h1235);
        @(negedge clk);
        // 3: PC wrap
        pc_ld = 1; pc_in = 16'hFFFF;
        @(negedge clk); pc_ld = 0;
        do_fetch(0, 16'h0000, 0, 16'h7E81);
        chk("t3_ir", ir_data, 16'h7E81);
        @(negedge clk);
        chk("t3_pc", pc_out, 16'h0000);
        chk("t3_addr", mem_addr, 16'hFFFF);
        chk("t3_err", bus_err, 1'b0);
        // 4: timeout, clear, ack on the last allowed cycle, set beats clear
        to_fetch(0);
        chk("t4_req_cycles", 16'(req_cycles), 16'd15);
        chk("t4_err", bus_err, 1'b1);
        chk("t4_done", fetch_done, 1'b1);
        chk("t4_ld", ld_ir, 1'b0);
        chk("t4_pc", pc_out, 16'h0000);
        chk("t4_ir", ir_data, 16'h7E81);
        err_clr = 1;
        @(negedge clk); err_clr = 0;
        chk("t4_clr", bus_err, 1'b0);
        do_fetch(0, 16'h0000, TIMEOUT - 1, 16'h3C3C);
        chk("t4b_err", bus_err, 1'b0);
        chk("t4b_ld", ld_ir, 1'b1);
        chk("t4b_ir", ir_data, 16'h3C3C);
        chk("t4b_pc", pc_out, 16'h0001);
        @(negedge clk);
        to_fetch(1);
        chk("t4c_set_wins", bus_err, 1'b1);
        @(negedge clk); err_clr = 0;
        chk("t4c_cleared", bus_err, 1'b0);
        // 5: asynchronous reset mid-WAIT, then a late ack
        @(negedge clk); pc_ld = 1; pc_in = 16'h5555; fetch_en = 1;
        @(negedge clk); pc_ld = 0; fetch_en = 0;
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("t5_req", mem_req, 1'b0);
        chk("t5_addr", mem_addr, 16'h0000);
        chk("t5_ir", ir_data, 16'h0000);
        chk("t5_busy", busy, 1'b0);
        chk("t5_pc", pc_out, 16'h0000);
        mem_ack = 1; mem_rdata = 16'hDEAD;
        @(negedge clk); rst = 0;
        repeat (2) @(negedge clk);
        chk("t5_late_ld", ld_ir, 1'b0);
        chk("t5_late_ir", ir_data, 16'h0000);
        chk("t5_late_pc", pc_out, 16'h0000);
        mem_ack = 0;
        // 6: back-to-back fetches, pc_ld/pc_in raised mid-WAIT are ignored
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk("t6_ld", ld_ir, 1'((k % 3) == 2));
                if (k % 3 == 2) begin
                    chk("t6_ir", ir_data, 16'(k / 3 + 1));
                    chk("t6_pc", pc_out, 16'(k / 3 + 1));
                end
            end
            fetch_en = 1; mem_ack = 1; mem_rdata = 16'(k / 3 + 1);
            pc_ld = (k % 3) == 1; pc_in = 16'hBEEF;
        end
        @(negedge clk); fetch_en = 0; mem_ack = 0; pc_ld = 0;
        chk("t6_final_pc", pc_out, 16'h0003);
        chk("t6_model_pc", m_pc, 16'h0003);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction fetch controller: the writer side of the 16-bit instruction register.
- Holds the program counter and runs a request/acknowledge read on instruction memory.
- Drives the IR load interface: one ir_data word plus a one-cycle ld_ir strobe per fetch.
- Sits between the CPU control FSM (fetch_en, pc_ld) and the memory port.

Parameters:
- RESET_PC, 16'h0000, PC value after reset.
- TIMEOUT, 15, max cycles in WAIT without mem_ack before aborting (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fetch_en  in  1  start fetch; sampled only in IDLE.
- pc_ld  in  1  load PC from pc_in; sampled only in IDLE.
- pc_in  in  16  branch/jump target.
- err_clr  in  1  clears sticky bus_err.
- mem_req  out  1  memory read request.
- mem_addr  out  16  read address.
- mem_rdata  in  16  memory read data, valid with mem_ack.
- mem_ack  in  1  read complete.
- ir_data  out  16  instruction word to IR input.
- ld_ir  out  1  one-cycle load strobe to IR.
- fetch_done  out  1  one-cycle completion pulse (success or abort).
- busy  out  1  high in WAIT and DONE.
- bus_err  out  1  sticky timeout flag.
- pc_out  out  16  current PC.

Behaviour:
- All outputs are registered.
- Reset (async, any state including mid-fetch):
  - state=IDLE, pc=RESET_PC.
  - mem_req=0, mem_addr=0, ir_data=0, ld_ir=0, fetch_done=0, busy=0, bus_err=0, timeout counter=0.
- States: IDLE, WAIT, DONE.
- IDLE:
  - pc_ld=1: pc<=pc_in.
  - fetch_en=1: next state WAIT. mem_req<=1, busy<=1, counter<=0.
  - mem_addr<=pc_in if pc_ld is also high that cycle, else pc.
  - pc_ld and fetch_en together: load first, fetch the new address.
- WAIT:
  - mem_req=1; mem_addr held stable.
  - mem_ack sampled high (ack may arrive the first WAIT cycle):
    - ir_data<=mem_rdata, ld_ir<=1, fetch_done<=1.
    - pc<=pc+1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
    - mem_req<=0; next state DONE.
  - No ack: counter increments. On the cycle counter==TIMEOUT-1 with no ack:
    - mem_req<=0, bus_err<=1, fetch_done<=1, ld_ir stays 0.
    - pc unchanged, ir_data unchanged; next state DONE.
  - mem_ack on the timeout cycle: ack wins, normal completion, bus_err not set.
- DONE:
  - ld_ir and fetch_done high this cycle only; cleared next edge.
  - Unconditional next state IDLE; busy<=0.
  - Minimum fetch cycle: IDLE -> WAIT -> DONE -> IDLE, so back-to-back fetches are 3 cycles apart with zero-wait memory.
- Timing: ld_ir and ir_data are valid in the same cycle, so the IR captures the word at the DONE->IDLE edge.
- Ignored inputs:
  - mem_ack outside WAIT.
  - fetch_en and pc_ld outside IDLE (not queued).
- bus_err:
  - Set only by timeout.
  - Cleared by err_clr in any state; a set on the same cycle as err_clr wins.
  - Does not block further fetches.

Test Plan:
1. Reset, then fetch_en pulse; mem_ack=1 with rdata=16'hA5C3 on the first WAIT cycle -> mem_req high one cycle at addr 0000; next cycle ld_ir=1, ir_data=A5C3, fetch_done=1; pc_out=0001; then IDLE, busy=0.
2. pc_ld=1, pc_in=16'h1234, fetch_en=1 same cycle; ack after 3 wait cycles -> mem_addr=1234 and stable for 4 cycles; pc_out=1235 after completion.
3. pc_ld to FFFF, then fetch with ack -> pc_out=0000 after completion, no other side effects.
4. TIMEOUT=15, no ack -> mem_req high exactly 15 cycles; then bus_err=1, fetch_done=1, ld_ir=0, pc unchanged, ir_data unchanged. err_clr -> bus_err=0. Variant: ack on cycle 15 -> normal completion, bus_err=0.
5. Assert rst asynchronously in mid-WAIT -> all outputs zero immediately and pc=RESET_PC; a late mem_ack after reset is ignored.
6. Hold fetch_en high with zero-wait ack and instructions 0001,0002,0003 -> ld_ir pulses every 3 cycles; pc advances 0,1,2,3; fetch_en and pc_ld raised during WAIT have no effect.
